// File: rtl/button_encoder.sv
// Pushbutton front end: synchronises, debounces and press/release-qualifies four
// active-low buttons and emits a one-cycle encValid per clean single press.
module button_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] button_n,
  output logic       encInput_X,
  output logic       encInput_Y,
  output logic       encValid,
  output logic       multiPress
);

  localparam int            CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic {
    IDLE,
    RELEASE_WAIT
  } state_t;

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       w_pressed;
  logic [3:0]       r_candidate;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_stable;
  logic             r_stable_vld;
  logic             r_stable_chg;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_sym;
  logic [1:0]       w_sym_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_multi;
  logic             w_multi_nxt;

  // NOTE: async active-low reset; every flop lists negedge reset_n so it clears immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= button_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;

  // stable_vld marks that stable has been confirmed at least once since reset,
  // so the reset value of stable cannot be mistaken for a settled release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_candidate  <= 4'h0;
      r_count      <= '0;
      r_stable     <= 4'h0;
      r_stable_vld <= 1'b0;
      r_stable_chg <= 1'b0;
    end else begin
      r_stable_chg <= 1'b0;
      if (w_pressed != r_candidate) begin
        r_candidate <= w_pressed;
        r_count     <= CNT_W'(1);
      end else if (r_count < CNT_MAX) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (r_count == CNT_MAX) begin
        r_stable     <= r_candidate;
        r_stable_vld <= 1'b1;
        r_stable_chg <= (r_candidate != r_stable);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RELEASE_WAIT;
      r_sym   <= 2'b00;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sym   <= w_sym_nxt;
      r_valid <= w_valid_nxt;
      r_multi <= w_multi_nxt;
    end
  end

  // NOTE: combinational blocks assign a default to every output first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:         if (r_stable_chg && (r_stable != 4'h0)) w_state_nxt = RELEASE_WAIT;
      RELEASE_WAIT: if (r_stable_vld && (r_stable == 4'h0)) w_state_nxt = IDLE;
      default:      w_state_nxt = RELEASE_WAIT;
    endcase
  end

  always_comb begin
    w_sym_nxt   = r_sym;
    w_valid_nxt = 1'b0;
    w_multi_nxt = 1'b0;
    if ((r_state == IDLE) && r_stable_chg && (r_stable != 4'h0)) begin
      case (r_stable)
        4'b0001: begin w_sym_nxt = 2'd0; w_valid_nxt = 1'b1; end
        4'b0010: begin w_sym_nxt = 2'd1; w_valid_nxt = 1'b1; end
        4'b0100: begin w_sym_nxt = 2'd2; w_valid_nxt = 1'b1; end
        4'b1000: begin w_sym_nxt = 2'd3; w_valid_nxt = 1'b1; end
        default: w_multi_nxt = 1'b1;
      endcase
    end
  end

  assign encInput_X = r_sym[1];
  assign encInput_Y = r_sym[0];
  assign encValid   = r_valid;
  assign multiPress = r_multi;

endmodule

// File: tb/tb_button_encoder.sv
// Self-checking bench for button_encoder: directed scenarios plus random bouncing,
// checked cycle by cycle against a debounce-window reference model.
module tb_button_encoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] button_n = 4'hF;
  logic       encInput_X, encInput_Y, encValid, multiPress;

  int total = 0;
  int bad   = 0;

  button_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .button_n   (button_n),
    .encInput_X (encInput_X),
    .encInput_Y (encInput_Y),
    .encValid   (encValid),
    .multiPress (multiPress)
  );

  always #5 clk = ~clk;

  // Reference model: raw[k] is the active-high pattern sampled at edge k after
  // reset; the debouncer sees it two edges later, and stable is confirmed at
  // edge k when the last D patterns it saw are identical.
  logic [3:0] raw [0:4095];
  int         k = 0;
  logic [3:0] m_stable = 4'h0;
  bit         m_est = 1'b0, m_chg = 1'b0, armed = 1'b0;
  logic       exp_x = 1'b0, exp_y = 1'b0, exp_v = 1'b0, exp_m = 1'b0;
  int         n_valid = 0, n_multi = 0;

  function automatic logic [3:0] seen(int j);
    return (j >= 3) ? raw[j-2] : 4'h0;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, expv, k);
    end
  endtask

  task automatic step();
    logic [3:0] nv;
    bit         same;
    @(posedge clk);
    if (!reset_n) begin
      k = 0; m_stable = 4'h0; m_est = 0; m_chg = 0; armed = 0;
      exp_x = 0; exp_y = 0; exp_v = 0; exp_m = 0;
    end else begin
      k++;
      if (k < 4096) raw[k] = ~button_n;
      exp_v = 0; exp_m = 0;
      if (armed) begin
        if (m_chg && m_stable != 4'h0) begin
          armed = 0;
          if ($countones(m_stable) == 1) begin
            exp_v = 1;
            for (int i = 0; i < 4; i++)
              if (m_stable[i]) {exp_x, exp_y} = 2'(i);
          end else begin
            exp_m = 1;
          end
        end
      end else if (m_est && m_stable == 4'h0) begin
        armed = 1;
      end
      m_chg = 0;
      if (k - D >= 1) begin
        nv = seen(k - 1);
        same = 1;
        for (int j = k - D; j < k; j++) if (seen(j) != nv) same = 0;
        if (same) begin
          m_chg = (nv != m_stable);
          m_stable = nv;
          m_est = 1;
        end
      end
    end
    #1;
    check("encValid", 32'(encValid), 32'(exp_v));
    check("multiPress", 32'(multiPress), 32'(exp_m));
    check("encInput_X", 32'(encInput_X), 32'(exp_x));
    check("encInput_Y", 32'(encInput_Y), 32'(exp_y));
    if (encValid) n_valid++;
    if (multiPress) n_multi++;
  endtask

  task automatic hold(logic [3:0] b, int n);
    button_n = b;
    for (int i = 0; i < n; i++) step();
  endtask

  // Holds b for up to 'budget' edges (edge 0 first) and returns the edge index
  // of the first encValid, or -1 if none appears within the budget.
  task automatic press_latency(logic [3:0] b, int budget, output int lat);
    lat = -1;
    button_n = b;
    for (int i = 0; i < budget; i++) begin
      step();
      if (encValid && lat < 0) lat = i;
    end
  endtask

  int lat;
  int v0, m0;

  initial begin
    // Reset
    reset_n = 1'b0; button_n = 4'hF;
    for (int i = 0; i < 3; i++) step();
    #1 reset_n = 1'b1;
    v0 = n_valid; m0 = n_multi;
    hold(4'hF, 20);
    check("reset_no_pulse", 32'(n_valid + n_multi - v0 - m0), 32'd0);

    // Clean press of button2
    v0 = n_valid;
    press_latency(4'b1011, 30, lat);
    check("clean_latency", 32'(lat), 32'(D + 3));
    check("clean_pulses", 32'(n_valid - v0), 32'd1);
    check("clean_sym", 32'({encInput_X, encInput_Y}), 32'd2);
    hold(4'hF, 12);

    // Bounce on button1, then settle low
    v0 = n_valid;
    for (int i = 0; i < 6; i++) hold((i % 2 == 0) ? 4'b1101 : 4'b1111, 2);
    press_latency(4'b1101, 20, lat);
    check("bounce_latency", 32'(lat), 32'(D + 3));
    check("bounce_pulses", 32'(n_valid - v0), 32'd1);
    check("bounce_sym", 32'({encInput_X, encInput_Y}), 32'd1);
    hold(4'hF, 12);

    // Multi-press from last symbol 2'b10
    hold(4'b1011, 12);
    hold(4'hF, 12);
    v0 = n_valid; m0 = n_multi;
    hold(4'b0110, 20);
    check("multi_pulses", 32'(n_multi - m0), 32'd1);
    check("multi_no_valid", 32'(n_valid - v0), 32'd0);
    check("multi_sym_held", 32'({encInput_X, encInput_Y}), 32'd2);
    hold(4'hF, 12);
    v0 = n_valid;
    hold(4'b0111, 15);
    check("after_multi_valid", 32'(n_valid - v0), 32'd1);
    check("after_multi_sym", 32'({encInput_X, encInput_Y}), 32'd3);
    hold(4'hF, 12);

    // Repeated press of button0 with a short and a long release
    v0 = n_valid;
    hold(4'b1110, 15);
    hold(4'hF, 3);
    hold(4'b1110, 15);
    hold(4'hF, 10);
    hold(4'b1110, 15);
    check("repeat_pulses", 32'(n_valid - v0), 32'd2);
    check("repeat_sym", 32'({encInput_X, encInput_Y}), 32'd0);
    hold(4'hF, 12);

    // Reset in the middle of a button1 press
    v0 = n_valid;
    hold(4'b1101, 6);
    reset_n = 1'b0;
    #1 check("midreset_valid_now", 32'(encValid), 32'd0);
    hold(4'b1101, 3);
    reset_n = 1'b1;
    hold(4'b1101, 20);
    check("midreset_no_valid", 32'(n_valid - v0), 32'd0);
    check("midreset_sym_zero", 32'({encInput_X, encInput_Y}), 32'd0);
    hold(4'hF, 12);
    press_latency(4'b1101, 15, lat);
    check("midreset_repress", 32'(n_valid - v0), 32'd1);
    check("midreset_sym", 32'({encInput_X, encInput_Y}), 32'd1);
    hold(4'hF, 12);

    // Random segments: single, multi or released patterns of random length
    for (int s = 0; s < 80; s++) begin
      logic [3:0] pat;
      case ($urandom_range(2))
        0:       pat = 4'hF;
        1:       pat = ~(4'b0001 << $urandom_range(3));
        default: pat = 4'($urandom);
      endcase
      hold(pat, $urandom_range(1, 12));
    end
    hold(4'hF, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_encoder.md
# button_encoder

Front-end input block for the combination-lock datapath. It turns four raw, bouncing, active-low pushbuttons into the 2-bit symbol {encInput_X, encInput_Y} that the lock's next-state logic consumes. Each clean press produces exactly one `encValid` pulse, which the state register uses as its load enable. The block synchronises, debounces and press/release-qualifies the buttons, rejects multi-button presses, and holds the last accepted symbol stable between presses.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised cycles a button pattern must stay unchanged to be accepted. Legal range 2..65535. The counter width is derived from it.
- `clk`  in  1  system clock; all flops are on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset. It asserts immediately and must be released synchronously to `clk` by the board-level reset logic.
- `button_n`  in  4  raw pushbuttons, active-low, asynchronous to `clk`. Bit i is symbol i.
- `encInput_X`  out  1  symbol MSB; holds the last accepted value.
- `encInput_Y`  out  1  symbol LSB; holds the last accepted value.
- `encValid`  out  1  one-cycle pulse marking a newly accepted symbol.
- `multiPress`  out  1  one-cycle pulse when a stable pattern has two or more buttons pressed.

## Operation
- **Synchroniser.** Each `button_n` bit passes through a 2-flop synchroniser and is then inverted to active-high (`pressed[3:0]`). Synchroniser flops reset to 1, meaning released.
- **Debouncer, candidate register.** `candidate` holds the pattern being tested; `count` is its stability counter.
  - If `pressed` != `candidate`: load `candidate` <= `pressed` and `count` <= 1.
  - Otherwise, if `count` < `DEBOUNCE_CYCLES`: increment `count`.
  - When `count` reaches `DEBOUNCE_CYCLES`, `stable` <= `candidate`, and `stableChg` pulses for one cycle if `stable` changes.
  - Reset values: `candidate`=0, `count`=0, `stable`=0.
- **FSM states:** IDLE, RELEASE_WAIT. The reset state is RELEASE_WAIT.
  - RELEASE_WAIT -> IDLE when `stable`==0 is established, i.e. all buttons released and stable.
  - IDLE, `stableChg` with exactly one bit i set: register {X,Y} <= i[1:0], pulse `encValid`, go to RELEASE_WAIT.
  - IDLE, `stableChg` with two or more bits set: pulse `multiPress`, leave X/Y unchanged, go to RELEASE_WAIT.
  - In RELEASE_WAIT, any pattern other than all-released produces no output.
- **Encoding:** button0 -> X=0,Y=0; button1 -> 0,1; button2 -> 1,0; button3 -> 1,1.
- **Multi-press.** A second button added while one is already accepted is ignored, since the FSM is already in RELEASE_WAIT. There is no second pulse.
- **Buttons held at reset.** Because the reset state is RELEASE_WAIT, a button held through reset release is never emitted. It must be released and pressed again.
- **Glitch rejection.** Any bounce or glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles reloads `candidate`/`count` and never reaches `stable`.
- **Reset mid-press.** Asserting `reset_n` during debounce or release aborts the operation immediately: outputs clear and the state returns to RELEASE_WAIT.

## Timing
- **Reset values:** `encInput_X`=0, `encInput_Y`=0, `encValid`=0, `multiPress`=0. Outputs are registered and do not glitch.
- **Press latency.** Edge 0 is the first rising edge that samples a settled press in `button_n` (after the prior all-released state is stable in IDLE). `stable` updates at edge `DEBOUNCE_CYCLES`+2, and `encValid` is high from edge `DEBOUNCE_CYCLES`+3 to edge `DEBOUNCE_CYCLES`+4. With the default this is edge 7.
- **Symbol hold.** `encInput_X`/`encInput_Y` change on the same edge that `encValid` rises and hold until the next accepted press.
- **Release latency.** After the last button is released (edge 0), the FSM reaches IDLE at edge `DEBOUNCE_CYCLES`+3. A press sampled before that point, with no settled release, is not a new symbol.
- **Pulse rules.** `encValid` and `multiPress` are never high in the same cycle, and each is at most one cycle per press.
- **No backpressure.** The consumer must accept `encValid` in the cycle it is high.

## Test plan
- **Reset.** Hold `reset_n`=0 with `button_n`=4'b1111, then release. Required: all outputs 0 and no pulses for 20 cycles.
- **Clean press.** `DEBOUNCE_CYCLES`=4; drive `button_n`=4'b1011 (button2) at edge 0 and hold for 30 cycles. Required: a single `encValid` pulse registered at edge 7, X=1, Y=0 held afterwards, and no further pulse while held.
- **Bounce.** Toggle button1 every 2 cycles for 12 cycles, then hold low. Required: exactly one `encValid` with X=0, Y=1, registered 7 edges after the final settle.
- **Multi-press.** From IDLE with last symbol 2'b10, press buttons 0 and 3 simultaneously. Required: one `multiPress` pulse, no `encValid`, X/Y still 1/0. After full release, pressing button3 yields `encValid` with X=1, Y=1.
- **Repeated press.** Press button0, release for 3 cycles, press again, then release for 10 cycles and press again. Required: `encValid` pulses for the first and third presses only, each with X=0, Y=0.
- **Reset mid-press.** Assert `reset_n`=0 at edge 5 of a button1 press, release it at edge 8 while still pressed. Required: no `encValid` and outputs 0 until the button is released, stable, and pressed again.
